// File: rtl/ym3438_pkg.sv
// Shared slot-sequencer constants and types for the YM3438 core.
package ym3438_pkg;

   localparam int unsigned NUM_CH = 6;
   localparam int unsigned NUM_OP = 4;
   localparam int unsigned SLOTS  = NUM_CH * NUM_OP;

   // Operator groups in chip time order
   localparam logic [1:0] OP1 = 2'd0;
   localparam logic [1:0] OP3 = 2'd1;
   localparam logic [1:0] OP2 = 2'd2;
   localparam logic [1:0] OP4 = 2'd3;

   typedef logic [4:0] slot_t;
   typedef logic [2:0] ch_t;
   typedef logic [1:0] op_t;

   // op*6 + ch without a multiplier
   function automatic slot_t slot_of(input op_t op, input ch_t ch);
      return slot_t'({op, 2'b00}) + slot_t'({op, 1'b0}) + slot_t'(ch);
   endfunction

endpackage

// File: rtl/ym3438_phase_edge.sv
// Rising-edge detector for a prescaler phase enable sampled on MCLK.
module ym3438_phase_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic d_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_prev <= 1'b0;
      end else begin
         d_prev <= d;
      end
   end

   assign rise = d & ~d_prev;

endmodule

// File: rtl/ym3438_slot_fsm.sv
// YM3438 24-slot sequencer: phase-1 counter plus phase-2 registered decodes.
// Optional clock checker enabled by defining YM3438_FSM_CLKCHK_EN.
module ym3438_slot_fsm
   import ym3438_pkg::*;
#(
   parameter int unsigned NUM_CH = 6,
   parameter int unsigned NUM_OP = 4
) (
   input  logic       MCLK,
   input  logic       IC,
   input  logic       c1,
   input  logic       c2,
   input  logic       reset_fsm,
   output logic [2:0] fsm_ch,
   output logic [1:0] fsm_op,
   output logic [4:0] fsm_slot,
   output logic [3:0] fsm_op_sel,
   output logic       fsm_ch3_sel,
   output logic       fsm_dac_sel,
   output logic       fsm_sync,
   output logic       clk_err
);

   localparam ch_t CH_LAST = ch_t'(NUM_CH - 1);
   localparam op_t OP_LAST = op_t'(NUM_OP - 1);

   logic  step1;
   logic  step2;
   ch_t   ch_nxt;
   op_t   op_nxt;
   logic [3:0] op_sel_nxt;

   ym3438_phase_edge u_edge_c1 (
      .clk   (MCLK),
      .rst_n (IC),
      .d     (c1),
      .rise  (step1)
   );

   ym3438_phase_edge u_edge_c2 (
      .clk   (MCLK),
      .rst_n (IC),
      .d     (c2),
      .rise  (step2)
   );

   // Channel values above CH_LAST are unreachable; treat them as a wrap.
   always_comb begin
      ch_nxt = fsm_ch;
      op_nxt = fsm_op;
      if (reset_fsm) begin
         ch_nxt = '0;
         op_nxt = '0;
      end else if (fsm_ch >= CH_LAST) begin
         ch_nxt = '0;
         op_nxt = (fsm_op >= OP_LAST) ? op_t'(0) : op_t'(fsm_op + 2'd1);
      end else begin
         ch_nxt = ch_t'(fsm_ch + 3'd1);
      end
   end

   always_comb begin
      op_sel_nxt = 4'b0000;
      unique case (fsm_op)
         OP1: op_sel_nxt = 4'b0001;
         OP3: op_sel_nxt = 4'b0010;
         OP2: op_sel_nxt = 4'b0100;
         OP4: op_sel_nxt = 4'b1000;
         default: op_sel_nxt = 4'b0000;
      endcase
   end

   // Phase-2 decode reads the pre-update counter when both steps coincide.
   always_ff @(posedge MCLK or negedge IC) begin
      if (!IC) begin
         fsm_ch      <= '0;
         fsm_op      <= '0;
         fsm_slot    <= '0;
         fsm_op_sel  <= '0;
         fsm_ch3_sel <= 1'b0;
         fsm_dac_sel <= 1'b0;
         fsm_sync    <= 1'b0;
      end else begin
         if (step1) begin
            fsm_ch   <= ch_nxt;
            fsm_op   <= op_nxt;
            fsm_slot <= slot_of(op_nxt, ch_nxt);
         end
         if (step2) begin
            fsm_op_sel  <= op_sel_nxt;
            fsm_ch3_sel <= (fsm_ch == 3'd2);
            fsm_dac_sel <= (fsm_ch == CH_LAST) && (fsm_op == OP_LAST);
            fsm_sync    <= (fsm_ch == 3'd0) && (fsm_op == 2'd0);
         end
      end
   end

`ifdef YM3438_FSM_CLKCHK_EN
   logic [2:0] idle_cnt;
   logic       err;

   always_ff @(posedge MCLK or negedge IC) begin
      if (!IC) begin
         idle_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if (c1 && c2) begin
            err <= 1'b1;
         end
         if (c1 || c2 || reset_fsm) begin
            idle_cnt <= '0;
         end else if (idle_cnt == 3'd7) begin
            err <= 1'b1;
         end else begin
            idle_cnt <= idle_cnt + 3'd1;
         end
      end
   end

   assign clk_err = err;
`else
   assign clk_err = 1'b0;
`endif

endmodule

// File: tb/tb_ym3438_slot_fsm.sv
// Randomized self-checking bench for ym3438_slot_fsm against a slot-index reference model.
module tb_ym3438_slot_fsm;

`ifdef YM3438_FSM_CLKCHK_EN
   localparam bit CLKCHK = 1'b1;
`else
   localparam bit CLKCHK = 1'b0;
`endif

   logic       MCLK;
   logic       IC;
   logic       c1;
   logic       c2;
   logic       reset_fsm;
   logic [2:0] fsm_ch;
   logic [1:0] fsm_op;
   logic [4:0] fsm_slot;
   logic [3:0] fsm_op_sel;
   logic       fsm_ch3_sel;
   logic       fsm_dac_sel;
   logic       fsm_sync;
   logic       clk_err;

   ym3438_slot_fsm dut (
      .MCLK        (MCLK),
      .IC          (IC),
      .c1          (c1),
      .c2          (c2),
      .reset_fsm   (reset_fsm),
      .fsm_ch      (fsm_ch),
      .fsm_op      (fsm_op),
      .fsm_slot    (fsm_slot),
      .fsm_op_sel  (fsm_op_sel),
      .fsm_ch3_sel (fsm_ch3_sel),
      .fsm_dac_sel (fsm_dac_sel),
      .fsm_sync    (fsm_sync),
      .clk_err     (clk_err)
   );

   initial begin
      MCLK = 1'b0;
      forever #5 MCLK = ~MCLK;
   end

   wire [17:0] obs = {fsm_ch, fsm_op, fsm_slot, fsm_op_sel, fsm_ch3_sel, fsm_dac_sel,
                      fsm_sync, clk_err};

   int n_chk  = 0;
   int n_pass = 0;
   int ph     = 0;

   // Reference model: linear slot index; m_p2 is the slot latched at the last c2 (-1 = none)
   int m_slot;
   int m_p2;
   int m_quiet;
   bit m_c1d;
   bit m_c2d;
   bit m_err;

   always @(posedge MCLK or negedge IC) begin
      if (!IC) begin
         m_slot  <= 0;
         m_p2    <= -1;
         m_c1d   <= 1'b0;
         m_c2d   <= 1'b0;
         m_err   <= 1'b0;
         m_quiet <= 0;
      end else begin
         m_c1d <= c1;
         m_c2d <= c2;
         if (c1 && !m_c1d) m_slot <= reset_fsm ? 0 : (m_slot + 1) % 24;
         if (c2 && !m_c2d) m_p2 <= m_slot;
         if (CLKCHK) begin
            if (c1 && c2) m_err <= 1'b1;
            if (c1 || c2 || reset_fsm) m_quiet <= 0;
            else begin
               m_quiet <= m_quiet + 1;
               if (m_quiet + 1 >= 8) m_err <= 1'b1;
            end
         end
      end
   end

   function automatic logic [17:0] exp_vec();
      logic [3:0] os;
      logic       ch3, dac, syn;
      os = 4'b0000; ch3 = 1'b0; dac = 1'b0; syn = 1'b0;
      if (m_p2 >= 0) begin
         os  = 4'b0001 << (m_p2 / 6);
         ch3 = (m_p2 % 6 == 2);
         dac = (m_p2 == 23);
         syn = (m_p2 == 0);
      end
      return {3'(m_slot % 6), 2'(m_slot / 6), 5'(m_slot), os, ch3, dac, syn, m_err};
   endfunction

   task automatic step(input bit a, input bit b, input bit r);
      c1 = a;
      c2 = b;
      reset_fsm = r;
      @(posedge MCLK);
      #1;
   endtask

   task automatic std_step(input bit r);
      step(ph < 2, (ph == 3) || (ph == 4), r);
      ph = (ph + 1) % 6;
   endtask

   task automatic test_reset();
      IC = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(i[0], ~i[0], 1'b0);
         n_chk++;
         if (obs !== 18'd0) $display("FAIL reset: got %h want %h", obs, 18'd0);
         else n_pass++;
      end
      IC = 1'b1;
      ph = 0;
   endtask

   task automatic test_frame();
      int syncs = 0;
      for (int i = 0; i < 24 + 144; i++) begin
         std_step(1'b0);
         if (i >= 24 && fsm_sync === 1'b1) syncs++;
         n_chk++;
         if (obs !== exp_vec()) $display("FAIL frame[%0d]: got %h want %h", i, obs, exp_vec());
         else n_pass++;
      end
      n_chk++;
      if (syncs !== 6) $display("FAIL sync_width: got %0d want 6", syncs);
      else n_pass++;
   endtask

   task automatic test_reset_fsm_pulse();
      int guard = 0;
      while (!(m_slot == 13 && ph == 0) && guard < 300) begin
         std_step(1'b0);
         guard++;
      end
      n_chk++;
      if (guard >= 300) $display("FAIL pulse_align: got timeout want slot 13");
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         std_step(i < 2);
         n_chk++;
         if (obs !== exp_vec()) $display("FAIL pulse[%0d]: got %h want %h", i, obs, exp_vec());
         else n_pass++;
      end
      n_chk++;
      if ({fsm_slot, fsm_sync, fsm_op_sel} !== {5'd0, 1'b1, 4'b0001})
         $display("FAIL pulse_result: got slot %0d sync %b sel %b want 0 1 0001",
                  fsm_slot, fsm_sync, fsm_op_sel);
      else n_pass++;
   endtask

   task automatic test_reset_fsm_hold();
      int guard = 0;
      while (ph != 0 && guard < 10) begin
         std_step(1'b0);
         guard++;
      end
      for (int i = 0; i < 18; i++) begin
         std_step(1'b1);
         n_chk++;
         if (obs !== exp_vec()) $display("FAIL hold[%0d]: got %h want %h", i, obs, exp_vec());
         else n_pass++;
      end
      n_chk++;
      if ({fsm_slot, fsm_sync} !== {5'd0, 1'b1})
         $display("FAIL hold_result: got slot %0d sync %b want 0 1", fsm_slot, fsm_sync);
      else n_pass++;
      for (int i = 0; i < 6; i++) std_step(1'b0);
      n_chk++;
      if (fsm_slot !== 5'd1) $display("FAIL hold_resume: got %0d want 1", fsm_slot);
      else n_pass++;
   endtask

   task automatic test_async_ic();
      int guard = 0;
      while (!(m_slot == 17 && ph == 2) && guard < 300) begin
         std_step(1'b0);
         guard++;
      end
      n_chk++;
      if (guard >= 300) $display("FAIL async_align: got timeout want slot 17");
      else n_pass++;
      #2;
      IC = 1'b0;
      #1;
      n_chk++;
      if (obs !== 18'd0) $display("FAIL async_ic: got %h want %h", obs, 18'd0);
      else n_pass++;
      step(1'b0, 1'b0, 1'b0);
      IC = 1'b1;
      ph = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom % 2), 1'($urandom % 2), ($urandom % 16) == 0);
         n_chk++;
         if (obs !== exp_vec()) $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec());
         else n_pass++;
      end
   endtask

   task automatic test_clkchk();
      IC = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      IC = 1'b1;
      ph = 0;
      step(1'b1, 1'b1, 1'b0);
      n_chk++;
      if (clk_err !== CLKCHK) $display("FAIL clk_overlap: got %b want %b", clk_err, CLKCHK);
      else n_pass++;
      for (int i = 0; i < 12; i++) begin
         std_step(1'b0);
         n_chk++;
         if (obs !== exp_vec()) $display("FAIL clk_sticky[%0d]: got %h want %h", i, obs, exp_vec());
         else n_pass++;
      end
      IC = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      IC = 1'b1;
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (clk_err !== 1'b0) $display("FAIL clk_idle7: got %b want 0", clk_err);
      else n_pass++;
      step(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (clk_err !== CLKCHK) $display("FAIL clk_idle8: got %b want %b", clk_err, CLKCHK);
      else n_pass++;
   endtask

   initial begin
      IC = 1'b0;
      c1 = 1'b0;
      c2 = 1'b0;
      reset_fsm = 1'b0;
      test_reset();
      test_frame();
      test_reset_fsm_pulse();
      test_reset_fsm_hold();
      test_async_ic();
      test_random();
      test_clkchk();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
